sram_burst_sequencer: RTL and testbench
=======================================

SRAM_BURST_SEQUENCER -- requirements
Module: sram_burst_sequencer

Interface
REQ-001 Parameter ADDR_W, default 16, SRAM address width.
REQ-002 Parameter DATA_W, default 8, SRAM data width.
REQ-003 Parameter KEY, default 8'hA5, expected access password.
REQ-004 Parameter MAX_FAILS, default 3, consecutive bad-password commands before lockout.
REQ-005 Parameter IDLE_TIMEOUT, default 16, idle cycles before sleep request.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 cmd_valid / cmd_ready  in / out  1 / 1  burst command handshake.
REQ-009 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-010 cmd_addr  in  ADDR_W  burst start address.
REQ-011 cmd_len  in  16  beat count.
REQ-012 cmd_password  in  8  password presented with the command.
REQ-013 wr_valid / wr_ready  in / out  1 / 1  write-beat data handshake.
REQ-014 wr_data  in  DATA_W  write-beat data.
REQ-015 rd_valid  out  1  one-cycle pulse; rd_data holds a read beat.
REQ-016 rd_data  out  DATA_W  read-beat data.
REQ-017 seq_addr  out  ADDR_W  address to the SRAM controller.
REQ-018 seq_we_n / seq_oe_n  out / out  1 / 1  active-low strobes to the controller.
REQ-019 seq_wdata / seq_rdata  out / in  DATA_W / DATA_W  controller data paths.
REQ-020 seq_burst_mode / seq_burst_length  out / out  1 / 16  burst qualifiers to the controller.
REQ-021 busy, done, cmd_error, locked, sleep_req  out  1 each  status outputs; done and cmd_error are one-cycle pulses.

Function
REQ-022 FSM states SHALL be IDLE, WR_STROBE, WR_RECOVER, RD_STROBE, RD_CAPTURE, FINISH, LOCKED.
REQ-023 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cycle cmd_valid & cmd_ready.
REQ-024 On accept, if cmd_password != KEY the block SHALL pulse cmd_error, increment the fail counter, and stay IDLE; on reaching MAX_FAILS it SHALL enter LOCKED.
REQ-025 On accept, if cmd_len == 0 the block SHALL pulse cmd_error, stay IDLE, and leave the fail counter unchanged.
REQ-026 A valid command SHALL clear the fail counter, latch addr/len/dir, drive seq_burst_mode=1 and seq_burst_length=cmd_len, and enter WR_STROBE or RD_STROBE.
REQ-027 In WR_STROBE, wr_ready=1; on wr_valid the block SHALL drive seq_we_n=0 with seq_wdata=wr_data for exactly one cycle, then go to WR_RECOVER (we_n=1) for one cycle. With no wr_valid it SHALL wait with we_n=1.
REQ-028 In RD_STROBE the block SHALL drive seq_oe_n=0 for one cycle. In RD_CAPTURE it SHALL register seq_rdata into rd_data and pulse rd_valid on the following cycle.
REQ-029 Per beat, seq_addr SHALL increment by 1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000); the beat counter SHALL decrement to 0.
REQ-030 After the last beat the FSM SHALL enter FINISH: pulse done, drop seq_burst_mode, and return to IDLE (one cycle).
REQ-031 seq_we_n and seq_oe_n SHALL never be 0 in the same cycle.
REQ-032 busy SHALL be 1 in every state except IDLE and LOCKED.
REQ-033 The idle counter SHALL count consecutive IDLE cycles without cmd_valid and assert sleep_req at IDLE_TIMEOUT, saturating there; any cmd_valid SHALL clear it and sleep_req in the same cycle.
REQ-034 LOCKED SHALL be exited only by reset; there cmd_ready=0 and locked=1.

Reset
REQ-035 Reset SHALL force IDLE, seq_addr=0, seq_we_n=1, seq_oe_n=1, seq_wdata=0, rd_data=0, seq_burst_mode=0, seq_burst_length=0, and all status pulses/counters=0.
REQ-036 Reset asserted mid-burst SHALL abort immediately; strobes return high asynchronously and no done pulse follows.

Structure
REQ-037 State encoding, KEY default, and the ADDR_W/DATA_W defaults SHALL live in a shared package sram_pkg, also used by the SRAM controller.
REQ-038 The idle/sleep counter SHALL be a sub-module, sram_idle_timer.

Verification
REQ-039 Write burst addr=0x0100, len=4, data CC,DD,EE,FF, pw=A5 -> four one-cycle we_n pulses at 0x0100..0x0103, done pulse after the 4th recovery.
REQ-040 Read burst of the same range with the controller model returning stored data -> rd_valid x4 with rd_data CC,DD,EE,FF in order; oe_n never overlaps we_n.
REQ-041 Three commands with pw=FF -> three cmd_error pulses, then locked=1, cmd_ready=0 until rst_n pulse.
REQ-042 Write addr=0xFFFF, len=2 -> beats at 0xFFFF then 0x0000.
REQ-043 rst_n low during beat 2 of a len=4 read -> strobes high immediately, no done, IDLE after release.
REQ-044 Idle 16 cycles -> sleep_req=1; cmd_valid raised -> sleep_req=0 same cycle.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM burst state encoding and interface defaults
package sram_pkg;
   localparam int         ADDR_W_DEF = 16;
   localparam int         DATA_W_DEF = 8;
   localparam logic [7:0] KEY_DEF    = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_STROBE,
      ST_WR_RECOVER,
      ST_RD_STROBE,
      ST_RD_CAPTURE,
      ST_FINISH,
      ST_LOCKED
   } seq_state_t;
endpackage

// File: rtl/sram_idle_timer.sv
// rtl/sram_idle_timer.sv - saturating idle counter raising a sleep request
module sram_idle_timer #(
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic idle,
   input  logic cmd_valid,
   output logic sleep_req
);
   localparam int              CNT_W = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(IDLE_TIMEOUT);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (cmd_valid || !idle)
         cnt_q <= '0;
      else if (cnt_q != LIMIT)
         cnt_q <= cnt_q + CNT_W'(1);
   end

   // Gated by cmd_valid so a waking command drops the request in its own cycle.
   assign sleep_req = (cnt_q == LIMIT) && !cmd_valid;
endmodule

// File: rtl/sram_burst_sequencer.sv
// rtl/sram_burst_sequencer.sv - password-gated burst sequencer driving SRAM controller strobes
module sram_burst_sequencer
   import sram_pkg::*;
#(
   parameter int         ADDR_W       = ADDR_W_DEF,
   parameter int         DATA_W       = DATA_W_DEF,
   parameter logic [7:0] KEY          = KEY_DEF,
   parameter int         MAX_FAILS    = 3,
   parameter int         IDLE_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [15:0]       cmd_len,
   input  logic [7:0]        cmd_password,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] seq_addr,
   output logic              seq_we_n,
   output logic              seq_oe_n,
   output logic [DATA_W-1:0] seq_wdata,
   input  logic [DATA_W-1:0] seq_rdata,
   output logic              seq_burst_mode,
   output logic [15:0]       seq_burst_length,
   output logic              busy,
   output logic              done,
   output logic              cmd_error,
   output logic              locked,
   output logic              sleep_req
);
   localparam int FAIL_W = $clog2(MAX_FAILS + 1);

   seq_state_t        state_q, state_d;
   logic [15:0]       beats_q;
   logic [FAIL_W-1:0] fail_q;
   logic              bad_pw, zero_len, start, beat_done, capture, wr_strobe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      bad_pw    = 1'b0;
      zero_len  = 1'b0;
      start     = 1'b0;
      beat_done = 1'b0;
      capture   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               // A bad password is charged even when the length is also zero.
               if (cmd_password != KEY) begin
                  bad_pw = 1'b1;
                  if (fail_q == FAIL_W'(MAX_FAILS - 1))
                     state_d = ST_LOCKED;
               end else if (cmd_len == 16'd0) begin
                  zero_len = 1'b1;
               end else begin
                  start   = 1'b1;
                  state_d = cmd_write ? ST_WR_STROBE : ST_RD_STROBE;
               end
            end
         end
         ST_WR_STROBE: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               beat_done = 1'b1;
               state_d   = ST_WR_RECOVER;
            end
         end
         ST_WR_RECOVER: state_d = (beats_q == 16'd0) ? ST_FINISH : ST_WR_STROBE;
         ST_RD_STROBE:  state_d = ST_RD_CAPTURE;
         ST_RD_CAPTURE: begin
            beat_done = 1'b1;
            capture   = 1'b1;
            state_d   = (beats_q == 16'd1) ? ST_FINISH : ST_RD_STROBE;
         end
         ST_FINISH:     state_d = ST_IDLE;
         ST_LOCKED:     state_d = ST_LOCKED;
         default:       state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_addr         <= '0;
         beats_q          <= '0;
         fail_q           <= '0;
         seq_burst_mode   <= 1'b0;
         seq_burst_length <= '0;
         cmd_error        <= 1'b0;
         rd_valid         <= 1'b0;
         rd_data          <= '0;
      end else begin
         cmd_error <= bad_pw | zero_len;
         rd_valid  <= 1'b0;
         if (bad_pw)
            fail_q <= fail_q + FAIL_W'(1);
         if (start) begin
            fail_q           <= '0;
            seq_addr         <= cmd_addr;
            beats_q          <= cmd_len;
            seq_burst_mode   <= 1'b1;
            seq_burst_length <= cmd_len;
         end
         if (beat_done) begin
            seq_addr <= seq_addr + ADDR_W'(1);
            beats_q  <= beats_q - 16'd1;
         end
         if (capture) begin
            rd_data  <= seq_rdata;
            rd_valid <= 1'b1;
         end
         if (state_q == ST_FINISH)
            seq_burst_mode <= 1'b0;
      end
   end

   // Strobes decode straight from the state register, so reset raises them at once
   // and the write and read strobes can never be low together.
   assign wr_strobe = (state_q == ST_WR_STROBE) && wr_valid;
   assign seq_we_n  = !wr_strobe;
   assign seq_wdata = wr_strobe ? wr_data : '0;
   assign seq_oe_n  = (state_q != ST_RD_STROBE);

   assign busy   = (state_q != ST_IDLE) && (state_q != ST_LOCKED);
   assign done   = (state_q == ST_FINISH);
   assign locked = (state_q == ST_LOCKED);

   sram_idle_timer #(
      .IDLE_TIMEOUT(IDLE_TIMEOUT)
   ) u_idle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .idle     (state_q == ST_IDLE),
      .cmd_valid(cmd_valid),
      .sleep_req(sleep_req)
   );
endmodule

// File: tb/tb_sram_burst_sequencer.sv
// tb/tb_sram_burst_sequencer.sv - directed self-checking bench for sram_burst_sequencer
module tb_sram_burst_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_addr, cmd_len;
   logic [7:0]  cmd_password;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_data;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic [15:0] seq_addr;
   logic        seq_we_n, seq_oe_n;
   logic [7:0]  seq_wdata, seq_rdata;
   logic        seq_burst_mode;
   logic [15:0] seq_burst_length;
   logic        busy, done, cmd_error, locked, sleep_req;

   always #5 clk = ~clk;

   sram_burst_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_password(cmd_password),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .seq_addr(seq_addr), .seq_we_n(seq_we_n), .seq_oe_n(seq_oe_n),
      .seq_wdata(seq_wdata), .seq_rdata(seq_rdata),
      .seq_burst_mode(seq_burst_mode), .seq_burst_length(seq_burst_length),
      .busy(busy), .done(done), .cmd_error(cmd_error), .locked(locked),
      .sleep_req(sleep_req)
   );

   logic [7:0]  mem [0:65535];
   logic [15:0] wr_addr_log [$];
   logic [7:0]  wr_data_log [$];
   logic [7:0]  rd_log [$];
   int          oe_cnt, overlap_cnt, done_cnt;
   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  pat [4] = '{8'hCC, 8'hDD, 8'hEE, 8'hFF};

   assign seq_rdata = mem[seq_addr];

   always @(posedge clk) begin
      if (!seq_we_n) begin
         mem[seq_addr] = seq_wdata;
         wr_addr_log.push_back(seq_addr);
         wr_data_log.push_back(seq_wdata);
      end
      if (!seq_oe_n) oe_cnt++;
      if (!seq_we_n && !seq_oe_n) overlap_cnt++;
      if (done) done_cnt++;
      if (rd_valid) rd_log.push_back(rd_data);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      wr_addr_log.delete();
      wr_data_log.delete();
      rd_log.delete();
      oe_cnt = 0;
      overlap_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [15:0] len,
                           input logic [7:0] pw);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_password = pw;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wr_beat(input logic [7:0] d);
      int t = 0;
      while (!wr_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("wr_ready", wr_ready, 1);
      wr_valid = 1'b1;
      wr_data  = d;
      @(negedge clk);
      wr_valid = 1'b0;
      check("we_n_recover", seq_we_n, 1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1);
   end

   initial begin
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_password = 0;
      wr_valid = 0; wr_data = 0;
      clear_logs();
      repeat (3) @(negedge clk);
      check("rst_we_n", seq_we_n, 1);
      check("rst_oe_n", seq_oe_n, 1);
      check("rst_addr", seq_addr, 0);
      check("rst_wdata", seq_wdata, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_burst_mode", seq_burst_mode, 0);
      check("rst_burst_len", seq_burst_length, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cmd_error", cmd_error, 0);
      check("rst_locked", locked, 0);
      check("rst_sleep", sleep_req, 0);
      check("rst_rd_valid", rd_valid, 0);
      rst_n = 1'b1;

      // idle timeout and wake
      repeat (15) @(negedge clk);
      check("sleep_at_15", sleep_req, 0);
      @(negedge clk);
      check("sleep_at_16", sleep_req, 1);
      repeat (4) @(negedge clk);
      check("sleep_saturate", sleep_req, 1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_len = 16'd0; cmd_password = 8'hA5;
      #1;
      check("sleep_clear", sleep_req, 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("zero_len_err", cmd_error, 1);
      check("zero_len_idle", cmd_ready, 1);

      // write burst 0x0100 x4
      clear_logs();
      send_cmd(1'b1, 16'h0100, 16'd4, 8'hA5);
      check("wr_no_err", cmd_error, 0);
      check("wr_burst_mode", seq_burst_mode, 1);
      check("wr_burst_len", seq_burst_length, 4);
      check("wr_busy", busy, 1);
      check("wr_cmd_ready", cmd_ready, 0);
      for (int i = 0; i < 4; i++) wr_beat(pat[i]);
      check("wr_done", done, 1);
      @(negedge clk);
      check("wr_done_once", done, 0);
      check("wr_back_idle", cmd_ready, 1);
      check("wr_mode_drop", seq_burst_mode, 0);
      check("wr_beats", wr_addr_log.size(), 4);
      for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
         check("wr_addr", wr_addr_log[i], 32'h0100 + i);
         check("wr_data", wr_data_log[i], pat[i]);
      end

      // read the same range back
      clear_logs();
      send_cmd(1'b0, 16'h0100, 16'd4, 8'hA5);
      check("rd_first_oe", seq_oe_n, 0);
      repeat (12) @(negedge clk);
      check("rd_beats", rd_log.size(), 4);
      for (int i = 0; i < 4 && i < rd_log.size(); i++) check("rd_data", rd_log[i], pat[i]);
      check("rd_oe_pulses", oe_cnt, 4);
      check("rd_done_cnt", done_cnt, 1);
      check("rd_idle", cmd_ready, 1);

      // address wrap
      clear_logs();
      send_cmd(1'b1, 16'hFFFF, 16'd2, 8'hA5);
      wr_beat(8'h11);
      wr_beat(8'h22);
      check("wrap_done", done, 1);
      @(negedge clk);
      check("wrap_beats", wr_addr_log.size(), 2);
      if (wr_addr_log.size() == 2) begin
         check("wrap_addr0", wr_addr_log[0], 32'hFFFF);
         check("wrap_addr1", wr_addr_log[1], 32'h0000);
      end
      check("overlap", overlap_cnt, 0);

      // reset during beat 2 of a read
      clear_logs();
      send_cmd(1'b0, 16'h0100, 16'd4, 8'hA5);
      @(negedge clk);
      @(negedge clk);
      check("abort_oe_beat2", seq_oe_n, 0);
      check("abort_addr_beat2", seq_addr, 16'h0101);
      #1 rst_n = 1'b0;
      #1;
      check("abort_oe_high", seq_oe_n, 1);
      check("abort_busy", busy, 0);
      check("abort_addr", seq_addr, 0);
      check("abort_rd_valid", rd_valid, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_no_done", done_cnt, 0);
      check("abort_idle", cmd_ready, 1);

      // fail counter: cleared by a good command, untouched by zero length
      send_cmd(1'b1, 16'h0000, 16'd1, 8'hFF);
      check("bad1_err", cmd_error, 1);
      send_cmd(1'b1, 16'h0000, 16'd1, 8'hFF);
      check("bad2_err", cmd_error, 1);
      check("bad2_unlocked", locked, 0);
      send_cmd(1'b0, 16'h0100, 16'd1, 8'hA5);
      repeat (4) @(negedge clk);
      check("good_idle", cmd_ready, 1);
      send_cmd(1'b1, 16'h0000, 16'd1, 8'hFF);
      send_cmd(1'b1, 16'h0000, 16'd1, 8'hFF);
      check("clear_unlocked", locked, 0);
      check("clear_ready", cmd_ready, 1);
      send_cmd(1'b1, 16'h0000, 16'd0, 8'hA5);
      check("zl_err", cmd_error, 1);
      check("zl_unlocked", locked, 0);
      send_cmd(1'b1, 16'h0000, 16'd1, 8'hFF);
      check("bad3_err", cmd_error, 1);
      check("bad3_locked", locked, 1);
      check("bad3_ready", cmd_ready, 0);
      check("bad3_busy", busy, 0);
      cmd_valid = 1'b1; cmd_password = 8'hA5; cmd_len = 16'd1;
      repeat (3) @(negedge clk);
      cmd_valid = 1'b0;
      check("lock_hold", locked, 1);
      check("lock_we_n", seq_we_n, 1);
      check("lock_no_err", cmd_error, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("unlock_reset", locked, 0);
      check("unlock_ready", cmd_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
